sap_controller: RTL and testbench

//  SAP-1 control sequencer: T-state counter plus microcode decoder driving every bus control line.

---
 rtl/sap_controller.sv | 205 ++++++++++++++++++++
 tb/tb_sap_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sap_controller
//  Description : SAP-1 control sequencer. A T-state counter plus a microcode
//                decoder that drives every bus control line of the machine.
//                Controls are combinational from the current step, so the
//                datapath latches each control word on the next rising edge.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_STEPS   T-states per instruction (5..8)
//    EARLY_END   1: return to T0 after the opcode's last micro-op
//                0: always run all NUM_STEPS steps
//  Ports
//    clk         system clock, rising edge
//    reset       asynchronous, active-low
//    run         1: sequencer advances; 0: hold step, controls forced 0
//    opcode      IR[7:4]
//    carry_flag  registered ALU carry
//    zero_flag   registered ALU zero
//    tstate      current step, binary
//    halted      HLT has executed (cleared only by reset)
//    pc_out, pc_inc, pc_jump, mar_in, ram_out, ram_in, ir_in, ir_out,
//    a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in
//                bus / register control lines
// ============================================================================
module sap_controller #(
    parameter int NUM_STEPS = 5,
    parameter bit EARLY_END = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic [2:0] tstate,
    output logic       halted,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_jump,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ram_in,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flags_in,
    output logic       out_in
);

    localparam logic [2:0] c_T0 = 3'd0;
    localparam logic [2:0] c_T1 = 3'd1;
    localparam logic [2:0] c_T2 = 3'd2;
    localparam logic [2:0] c_T3 = 3'd3;
    localparam logic [2:0] c_T4 = 3'd4;
    localparam logic [2:0] c_T_FINAL = 3'(NUM_STEPS - 1);

    localparam logic [3:0] c_OP_LDA = 4'h1;
    localparam logic [3:0] c_OP_ADD = 4'h2;
    localparam logic [3:0] c_OP_SUB = 4'h3;
    localparam logic [3:0] c_OP_STA = 4'h4;
    localparam logic [3:0] c_OP_LDI = 4'h5;
    localparam logic [3:0] c_OP_JMP = 4'h6;
    localparam logic [3:0] c_OP_JC  = 4'h7;
    localparam logic [3:0] c_OP_JZ  = 4'h8;
    localparam logic [3:0] c_OP_OUT = 4'hE;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    logic [2:0] r_tstate;
    logic       r_halted;
    logic       w_advance;   // sequencer allowed to move this cycle
    logic       w_drive;     // control lines allowed to assert
    logic [2:0] w_last_step;
    logic       w_wrap;

    assign tstate = r_tstate;
    assign halted = r_halted;

    assign w_advance = run & ~r_halted;
    // Gating with reset keeps every control low for the whole time reset is
    // held, independent of the clock.
    assign w_drive   = reset & w_advance;

    always_comb begin
        w_last_step = c_T2;
        case (opcode)
            c_OP_ADD, c_OP_SUB: w_last_step = c_T4;
            c_OP_LDA, c_OP_STA: w_last_step = c_T3;
            default:            w_last_step = c_T2;
        endcase
    end

    assign w_wrap = (EARLY_END && (r_tstate == w_last_step)) ||
                    (r_tstate == c_T_FINAL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tstate <= c_T0;
            r_halted <= 1'b0;
        end else if (w_advance) begin
            if ((r_tstate == c_T2) && (opcode == c_OP_HLT)) begin
                // Machine freezes in T2; only reset leaves this state.
                r_halted <= 1'b1;
            end else if (w_wrap) begin
                r_tstate <= c_T0;
            end else begin
                r_tstate <= r_tstate + 3'd1;
            end
        end
    end

    always_comb begin
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        pc_jump  = 1'b0;
        mar_in   = 1'b0;
        ram_out  = 1'b0;
        ram_in   = 1'b0;
        ir_in    = 1'b0;
        ir_out   = 1'b0;
        a_in     = 1'b0;
        a_out    = 1'b0;
        b_in     = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        flags_in = 1'b0;
        out_in   = 1'b0;
        if (w_drive) begin
            case (r_tstate)
                c_T0: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                c_T1: begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                    pc_inc  = 1'b1;
                end
                c_T2: begin
                    case (opcode)
                        c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
                            ir_out = 1'b1;
                            mar_in = 1'b1;
                        end
                        c_OP_LDI: begin
                            ir_out = 1'b1;
                            a_in   = 1'b1;
                        end
                        c_OP_JMP: begin
                            ir_out  = 1'b1;
                            pc_jump = 1'b1;
                        end
                        c_OP_JC: begin
                            ir_out  = carry_flag;
                            pc_jump = carry_flag;
                        end
                        c_OP_JZ: begin
                            ir_out  = zero_flag;
                            pc_jump = zero_flag;
                        end
                        c_OP_OUT: begin
                            a_out  = 1'b1;
                            out_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                c_T3: begin
                    case (opcode)
                        c_OP_LDA: begin
                            ram_out = 1'b1;
                            a_in    = 1'b1;
                        end
                        c_OP_ADD, c_OP_SUB: begin
                            ram_out = 1'b1;
                            b_in    = 1'b1;
                            alu_sub = (opcode == c_OP_SUB);
                        end
                        c_OP_STA: begin
                            a_out  = 1'b1;
                            ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                c_T4: begin
                    if ((opcode == c_OP_ADD) || (opcode == c_OP_SUB)) begin
                        alu_out  = 1'b1;
                        a_in     = 1'b1;
                        flags_in = 1'b1;
                        alu_sub  = (opcode == c_OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sap_controller
//  Description : Directed self-checking bench for sap_controller. Instance A
//                uses EARLY_END=1, instance B uses EARLY_END=0. Expected step,
//                halt bit and control word are queued when stimulus is
//                applied and popped when the outputs are sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sap_controller;

    // Control word bit positions, MSB first:
    // pc_out pc_inc pc_jump mar_in ram_out ram_in ir_in ir_out
    // a_in a_out b_in alu_out alu_sub flags_in out_in
    localparam logic [14:0] c_PC_OUT   = 15'd1 << 14;
    localparam logic [14:0] c_PC_INC   = 15'd1 << 13;
    localparam logic [14:0] c_PC_JUMP  = 15'd1 << 12;
    localparam logic [14:0] c_MAR_IN   = 15'd1 << 11;
    localparam logic [14:0] c_RAM_OUT  = 15'd1 << 10;
    localparam logic [14:0] c_RAM_IN   = 15'd1 << 9;
    localparam logic [14:0] c_IR_IN    = 15'd1 << 8;
    localparam logic [14:0] c_IR_OUT   = 15'd1 << 7;
    localparam logic [14:0] c_A_IN     = 15'd1 << 6;
    localparam logic [14:0] c_A_OUT    = 15'd1 << 5;
    localparam logic [14:0] c_B_IN     = 15'd1 << 4;
    localparam logic [14:0] c_ALU_OUT  = 15'd1 << 3;
    localparam logic [14:0] c_ALU_SUB  = 15'd1 << 2;
    localparam logic [14:0] c_FLAGS_IN = 15'd1 << 1;
    localparam logic [14:0] c_OUT_IN   = 15'd1 << 0;
    localparam logic [14:0] c_NONE     = 15'd0;
    localparam logic [14:0] c_FETCH0   = c_PC_OUT | c_MAR_IN;
    localparam logic [14:0] c_FETCH1   = c_RAM_OUT | c_IR_IN | c_PC_INC;

    typedef struct {
        logic [2:0]  t;
        logic        h;
        logic [14:0] c;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       r_rst_a = 1'b0, r_run_a = 1'b1, r_cf_a = 1'b0, r_zf_a = 1'b0;
    logic [3:0] r_op_a = 4'h0;
    logic       r_rst_b = 1'b0, r_run_b = 1'b1, r_cf_b = 1'b0, r_zf_b = 1'b0;
    logic [3:0] r_op_b = 4'h0;

    logic [2:0]  w_t_a, w_t_b;
    logic        w_h_a, w_h_b;
    logic [14:0] w_c_a, w_c_b;

    sap_controller #(.NUM_STEPS(5), .EARLY_END(1'b1)) u_dut_a (
        .clk(clk), .reset(r_rst_a), .run(r_run_a), .opcode(r_op_a),
        .carry_flag(r_cf_a), .zero_flag(r_zf_a),
        .tstate(w_t_a), .halted(w_h_a),
        .pc_out(w_c_a[14]), .pc_inc(w_c_a[13]), .pc_jump(w_c_a[12]),
        .mar_in(w_c_a[11]), .ram_out(w_c_a[10]), .ram_in(w_c_a[9]),
        .ir_in(w_c_a[8]), .ir_out(w_c_a[7]), .a_in(w_c_a[6]),
        .a_out(w_c_a[5]), .b_in(w_c_a[4]), .alu_out(w_c_a[3]),
        .alu_sub(w_c_a[2]), .flags_in(w_c_a[1]), .out_in(w_c_a[0])
    );

    sap_controller #(.NUM_STEPS(5), .EARLY_END(1'b0)) u_dut_b (
        .clk(clk), .reset(r_rst_b), .run(r_run_b), .opcode(r_op_b),
        .carry_flag(r_cf_b), .zero_flag(r_zf_b),
        .tstate(w_t_b), .halted(w_h_b),
        .pc_out(w_c_b[14]), .pc_inc(w_c_b[13]), .pc_jump(w_c_b[12]),
        .mar_in(w_c_b[11]), .ram_out(w_c_b[10]), .ram_in(w_c_b[9]),
        .ir_in(w_c_b[8]), .ir_out(w_c_b[7]), .a_in(w_c_b[6]),
        .a_out(w_c_b[5]), .b_in(w_c_b[4]), .alu_out(w_c_b[3]),
        .alu_sub(w_c_b[2]), .flags_in(w_c_b[1]), .out_in(w_c_b[0])
    );

    task automatic push_exp(input logic [2:0] t, input logic h, input logic [14:0] c);
        exp_t e;
        e.t = t;
        e.h = h;
        e.c = c;
        sb.push_back(e);
    endtask

    // Pop one expectation and compare, plus the single-bus-driver rule.
    task automatic check(input string tag, input logic [2:0] ot, input logic oh,
                         input logic [14:0] oc);
        exp_t e;
        int   drivers;
        e = sb.pop_front();
        checks++;
        assert ({ot, oh, oc} === {e.t, e.h, e.c}) else begin
            failures++;
            $error("FAIL %s observed t=%0d h=%b ctrl=%h expected t=%0d h=%b ctrl=%h",
                   tag, ot, oh, oc, e.t, e.h, e.c);
        end
        drivers = $countones({oc[14], oc[10], oc[7], oc[5], oc[3]});
        checks++;
        assert (drivers <= 1) else begin
            failures++;
            $error("FAIL %s_bus observed drivers=%0d expected <=1", tag, drivers);
        end
    endtask

    task automatic cyc_a(input string tag, input logic [3:0] op, input logic run,
                         input logic cf, input logic zf,
                         input logic [2:0] et, input logic eh, input logic [14:0] ec);
        r_op_a  = op;
        r_run_a = run;
        r_cf_a  = cf;
        r_zf_a  = zf;
        push_exp(et, eh, ec);
        @(negedge clk);
        check(tag, w_t_a, w_h_a, w_c_a);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input string tag, input logic [3:0] op,
                         input logic [2:0] et, input logic [14:0] ec);
        r_op_b = op;
        push_exp(et, 1'b0, ec);
        @(negedge clk);
        check(tag, w_t_b, w_h_b, w_c_b);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_a(input string tag, input logic [3:0] op,
                           input logic cf, input logic zf);
        cyc_a({tag, "_t0"}, op, 1'b1, cf, zf, 3'd0, 1'b0, c_FETCH0);
        cyc_a({tag, "_t1"}, op, 1'b1, cf, zf, 3'd1, 1'b0, c_FETCH1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        push_exp(3'd0, 1'b0, c_NONE);
        check("reset_a", w_t_a, w_h_a, w_c_a);
        r_rst_a = 1'b1;

        // ADD then SUB with early end
        fetch_a("add", 4'h2, 1'b0, 1'b0);
        cyc_a("add_t2", 4'h2, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, c_IR_OUT | c_MAR_IN);
        cyc_a("add_t3", 4'h2, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, c_RAM_OUT | c_B_IN);
        cyc_a("add_t4", 4'h2, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, c_ALU_OUT | c_A_IN | c_FLAGS_IN);
        fetch_a("sub", 4'h3, 1'b0, 1'b0);
        cyc_a("sub_t2", 4'h3, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, c_IR_OUT | c_MAR_IN);
        cyc_a("sub_t3", 4'h3, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, c_RAM_OUT | c_B_IN | c_ALU_SUB);
        cyc_a("sub_t4", 4'h3, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0,
              c_ALU_OUT | c_A_IN | c_FLAGS_IN | c_ALU_SUB);

        // LDA with a 3-cycle run pause in T2
        fetch_a("lda", 4'h1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc_a("lda_pause", 4'h1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, c_NONE);
        cyc_a("lda_t2", 4'h1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, c_IR_OUT | c_MAR_IN);
        cyc_a("lda_t3", 4'h1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, c_RAM_OUT | c_A_IN);

        fetch_a("sta", 4'h4, 1'b0, 1'b0);
        cyc_a("sta_t2", 4'h4, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, c_IR_OUT | c_MAR_IN);
        cyc_a("sta_t3", 4'h4, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, c_A_OUT | c_RAM_IN);

        fetch_a("ldi", 4'h5, 1'b0, 1'b0);
        cyc_a("ldi_t2", 4'h5, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, c_IR_OUT | c_A_IN);
        fetch_a("jmp", 4'h6, 1'b0, 1'b0);
        cyc_a("jmp_t2", 4'h6, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, c_IR_OUT | c_PC_JUMP);

        // Conditional jumps, taken and not taken; flags set opposite on the
        // unused flag to catch a swapped selection.
        fetch_a("jc1", 4'h7, 1'b1, 1'b0);
        cyc_a("jc1_t2", 4'h7, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, c_IR_OUT | c_PC_JUMP);
        fetch_a("jc0", 4'h7, 1'b0, 1'b1);
        cyc_a("jc0_t2", 4'h7, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, c_NONE);
        fetch_a("jz1", 4'h8, 1'b0, 1'b1);
        cyc_a("jz1_t2", 4'h8, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, c_IR_OUT | c_PC_JUMP);
        fetch_a("jz0", 4'h8, 1'b1, 1'b0);
        cyc_a("jz0_t2", 4'h8, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, c_NONE);

        fetch_a("out", 4'hE, 1'b0, 1'b0);
        cyc_a("out_t2", 4'hE, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, c_A_OUT | c_OUT_IN);
        fetch_a("nop", 4'h0, 1'b0, 1'b0);
        cyc_a("nop_t2", 4'h0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, c_NONE);
        fetch_a("op9", 4'h9, 1'b0, 1'b0);
        cyc_a("op9_t2", 4'h9, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, c_NONE);

        // Asynchronous reset in the middle of ADD T3
        fetch_a("addr", 4'h2, 1'b0, 1'b0);
        cyc_a("addr_t2", 4'h2, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, c_IR_OUT | c_MAR_IN);
        push_exp(3'd3, 1'b0, c_RAM_OUT | c_B_IN);
        @(negedge clk);
        check("addr_t3", w_t_a, w_h_a, w_c_a);
        #1 r_rst_a = 1'b0;
        #1;
        push_exp(3'd0, 1'b0, c_NONE);
        check("rst_async", w_t_a, w_h_a, w_c_a);
        @(posedge clk);
        #1;
        push_exp(3'd0, 1'b0, c_NONE);
        check("rst_hold", w_t_a, w_h_a, w_c_a);
        r_rst_a = 1'b1;
        fetch_a("post_rst", 4'h2, 1'b0, 1'b0);
        cyc_a("post_rst_t2", 4'h2, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, c_IR_OUT | c_MAR_IN);
        cyc_a("post_rst_t3", 4'h2, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, c_RAM_OUT | c_B_IN);
        cyc_a("post_rst_t4", 4'h2, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0,
              c_ALU_OUT | c_A_IN | c_FLAGS_IN);

        // HLT: freezes at T2 with controls low, run toggling ignored
        fetch_a("hlt", 4'hF, 1'b0, 1'b0);
        cyc_a("hlt_t2", 4'hF, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, c_NONE);
        for (int i = 0; i < 20; i++)
            cyc_a("hlt_hold", 4'hF, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, c_NONE);
        cyc_a("hlt_run0", 4'h2, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, c_NONE);
        cyc_a("hlt_run1", 4'h2, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, c_NONE);
        r_rst_a = 1'b0;
        #1;
        push_exp(3'd0, 1'b0, c_NONE);
        check("hlt_reset", w_t_a, w_h_a, w_c_a);
        @(posedge clk);
        #1;
        r_rst_a = 1'b1;
        fetch_a("hlt_exit", 4'h0, 1'b0, 1'b0);

        // Instance B: EARLY_END=0, LDI runs all five steps then wraps
        r_rst_b = 1'b1;
        cyc_b("b_ldi_t0", 4'h5, 3'd0, c_FETCH0);
        cyc_b("b_ldi_t1", 4'h5, 3'd1, c_FETCH1);
        cyc_b("b_ldi_t2", 4'h5, 3'd2, c_IR_OUT | c_A_IN);
        cyc_b("b_ldi_t3", 4'h5, 3'd3, c_NONE);
        cyc_b("b_ldi_t4", 4'h5, 3'd4, c_NONE);
        cyc_b("b_wrap_t0", 4'h5, 3'd0, c_FETCH0);
        cyc_b("b_wrap_t1", 4'h5, 3'd1, c_FETCH1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
